led_fader: RTL and testbench

LED_FADER -- requirements
Module: led_fader

---
 rtl/led_fader.sv | 135 +++++++++++++
 tb/tb_led_fader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/led_fader.sv
// rtl/led_fader.sv - four-lane LED fader with shared prescaler and PWM
module led_fader #(
  parameter int TICK_DIV = 65536,
  parameter int STEP     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] pattern,
  output logic [3:0] leds,
  output logic       settled
);

  // Prescaler width covers TICK_DIV-1 for the full legal range (2..2^24).
  localparam int              PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [8:0]      STEP9     = 9'(STEP);
  localparam logic [7:0]      STEP8     = 8'(STEP);
  localparam logic [7:0]      LVL_MAX   = 8'hFF;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_RISE = 2'd1,
    S_ON   = 2'd2,
    S_FALL = 2'd3
  } state_t;

  logic [3:0]    pat_q, pat_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    pwm_q, pwm_d;
  logic [3:0]    leds_q, leds_d;
  logic          settled_q, settled_d;
  logic          tick;

  logic [7:0]    level_q [4];
  logic [7:0]    level_d [4];
  state_t        state_q [4];
  state_t        state_d [4];

  // Shared timebase: input capture, fade-step prescaler and PWM ramp.
  always_comb begin
    pat_d   = pattern;
    tick    = (presc_q == TICK_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
    pwm_d   = pwm_q + 8'd1;
  end

  // Per-lane fade FSM: direction follows pat_q every cycle, the level only moves on tick.
  always_comb begin
    state_t     dir;
    logic [8:0] sum9;
    dir  = S_OFF;
    sum9 = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      level_d[i] = level_q[i];

      // A reversal takes effect in the same cycle, so a coinciding tick
      // steps in the new direction from the current level.
      unique case (state_q[i])
        S_OFF:   dir = pat_q[i] ? S_RISE : S_OFF;
        S_RISE:  dir = pat_q[i] ? S_RISE : S_FALL;
        S_ON:    dir = pat_q[i] ? S_ON   : S_FALL;
        S_FALL:  dir = pat_q[i] ? S_RISE : S_FALL;
        default: dir = S_OFF;
      endcase
      state_d[i] = dir;

      // Rising sum is kept 9 bits wide so saturation never sees a wrapped value.
      sum9 = {1'b0, level_q[i]} + STEP9;

      if (dir == S_OFF) begin
        level_d[i] = 8'd0;
      end else if (dir == S_ON) begin
        level_d[i] = LVL_MAX;
      end else if (tick) begin
        if (dir == S_RISE) begin
          if (sum9 >= {1'b0, LVL_MAX}) begin
            level_d[i] = LVL_MAX;
            state_d[i] = S_ON;
          end else begin
            level_d[i] = sum9[7:0];
          end
        end else begin
          if (level_q[i] <= STEP8) begin
            level_d[i] = 8'd0;
            state_d[i] = S_OFF;
          end else begin
            level_d[i] = level_q[i] - STEP8;
          end
        end
      end
    end
  end

  // Output stage: PWM compare per lane (full level forces solid on) and settled flag.
  always_comb begin
    settled_d = 1'b1;
    leds_d    = '0;
    for (int i = 0; i < 4; i++) begin
      leds_d[i] = (level_q[i] == LVL_MAX) || (pwm_q < level_q[i]);
      if ((state_q[i] == S_RISE) || (state_q[i] == S_FALL)) begin
        settled_d = 1'b0;
      end
    end
  end

  // State register: reset abandons any fade and restarts the timebase from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q     <= '0;
      presc_q   <= '0;
      pwm_q     <= '0;
      leds_q    <= '0;
      settled_q <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        level_q[i] <= 8'd0;
        state_q[i] <= S_OFF;
      end
    end else begin
      pat_q     <= pat_d;
      presc_q   <= presc_d;
      pwm_q     <= pwm_d;
      leds_q    <= leds_d;
      settled_q <= settled_d;
      for (int i = 0; i < 4; i++) begin
        level_q[i] <= level_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign leds    = leds_q;
  assign settled = settled_q;

endmodule

// File: tb/tb_led_fader.sv
// tb/tb_led_fader.sv - directed self-checking bench for led_fader
module tb_led_fader;

  localparam int ST_OFF = 0;
  localparam int ST_ON  = 2;

  logic       clk = 1'b0;
  logic       rst_m, rst_s, rst_p;
  logic [3:0] pat_m, pat_s, pat_p;
  logic [3:0] leds_m, leds_s, leds_p;
  logic       settled_m, settled_s, settled_p;

  int n_checks = 0;
  int n_fail   = 0;

  logic mon_hi  = 1'b0;
  logic mon_rev = 1'b0;
  logic mon_sat = 1'b0;
  int   hi_viol  = 0;
  int   rev_viol = 0;
  int   sat_viol = 0;

  always #5 clk = ~clk;

  led_fader #(.TICK_DIV(4), .STEP(64)) u_main (
    .clk(clk), .rst(rst_m), .pattern(pat_m), .leds(leds_m), .settled(settled_m)
  );

  led_fader #(.TICK_DIV(2), .STEP(255)) u_sat (
    .clk(clk), .rst(rst_s), .pattern(pat_s), .leds(leds_s), .settled(settled_s)
  );

  led_fader #(.TICK_DIV(1024), .STEP(128)) u_pwm (
    .clk(clk), .rst(rst_p), .pattern(pat_p), .leds(leds_p), .settled(settled_p)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lvl(input int which, input logic [1:0] lane);
    case (which)
      0:       return u_main.level_q[lane];
      1:       return u_sat.level_q[lane];
      default: return u_pwm.level_q[lane];
    endcase
  endfunction

  // Waits (bounded) for the given lane's level to change; reports cycles taken and new level.
  task automatic wait_change(input int which, input logic [1:0] lane, input int budget,
                             output int cyc, output logic [7:0] val);
    logic [7:0] prev;
    prev = lvl(which, lane);
    val  = prev;
    cyc  = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (lvl(which, lane) != prev) begin
        val = lvl(which, lane);
        return;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_hi && (leds_m[3:1] != 3'b000)) hi_viol++;
    if (mon_rev && (u_main.level_q[1] == 8'hFF)) rev_viol++;
    if (mon_sat && (u_sat.level_q[0] != 8'h00) && (u_sat.level_q[0] != 8'hFF)) sat_viol++;
  end

  initial begin
    int         cyc;
    int         highs;
    logic [7:0] v;
    logic [7:0] rise_exp [4];
    logic [7:0] fall_exp [4];
    logic       ph0, ph127, ph128;

    rise_exp = '{8'd64, 8'd128, 8'd192, 8'd255};
    fall_exp = '{8'd191, 8'd127, 8'd63, 8'd0};

    rst_m = 1'b1; rst_s = 1'b1; rst_p = 1'b1;
    pat_m = 4'b0001; pat_s = 4'b0000; pat_p = 4'b0000;
    repeat (3) @(negedge clk);

    check_eq("rst_leds", 32'(leds_m), 32'd0);
    check_eq("rst_settled", 32'(settled_m), 32'd1);
    check_eq("rst_level0", 32'(u_main.level_q[0]), 32'd0);
    check_eq("rst_state0", 32'(u_main.state_q[0]), ST_OFF);

    // Rise of LED0: first step TICK_DIV cycles after release, then every TICK_DIV.
    rst_m  = 1'b0;
    mon_hi = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_change(0, 2'd0, 8, cyc, v);
      check_eq($sformatf("rise_val%0d", k), 32'(v), 32'(rise_exp[k]));
      check_eq($sformatf("rise_cyc%0d", k), 32'(cyc), 32'd4);
      if (k == 0) check_eq("settled_low_rise", 32'(settled_m), 32'd0);
    end
    check_eq("state_on", 32'(u_main.state_q[0]), ST_ON);
    check_eq("settled_at_255", 32'(settled_m), 32'd0);
    @(negedge clk);
    check_eq("settled_after_on", 32'(settled_m), 32'd1);

    highs = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (leds_m[0]) highs++;
    end
    check_eq("duty_255", 32'(highs), 32'd256);

    // Fall of LED0.
    pat_m = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      wait_change(0, 2'd0, 8, cyc, v);
      check_eq($sformatf("fall_val%0d", k), 32'(v), 32'(fall_exp[k]));
    end
    check_eq("state_off", 32'(u_main.state_q[0]), ST_OFF);
    @(negedge clk);
    check_eq("settled_after_off", 32'(settled_m), 32'd1);
    highs = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (leds_m[0]) highs++;
    end
    check_eq("duty_0", 32'(highs), 32'd0);
    mon_hi = 1'b0;
    check_eq("leds31_quiet", 32'(hi_viol), 32'd0);

    // Reversal on LED1 at level 128.
    pat_m   = 4'b0010;
    mon_rev = 1'b1;
    wait_change(0, 2'd1, 8, cyc, v);
    check_eq("rev_up64", 32'(v), 32'd64);
    wait_change(0, 2'd1, 8, cyc, v);
    check_eq("rev_up128", 32'(v), 32'd128);
    pat_m = 4'b0000;
    wait_change(0, 2'd1, 8, cyc, v);
    check_eq("rev_down64", 32'(v), 32'd64);
    check_eq("rev_no_skip", 32'(cyc <= 4), 32'd1);
    wait_change(0, 2'd1, 8, cyc, v);
    check_eq("rev_down0", 32'(v), 32'd0);
    check_eq("rev_down0_cyc", 32'(cyc), 32'd4);
    mon_rev = 1'b0;
    check_eq("rev_no_255", 32'(rev_viol), 32'd0);

    // Reset mid-rise at level 192.
    pat_m = 4'b0001;
    for (int k = 0; k < 3; k++) wait_change(0, 2'd0, 8, cyc, v);
    check_eq("mid_level192", 32'(v), 32'd192);
    rst_m = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_level", 32'(u_main.level_q[0]), 32'd0);
    check_eq("mid_rst_leds", 32'(leds_m), 32'd0);
    check_eq("mid_rst_settled", 32'(settled_m), 32'd1);
    check_eq("mid_rst_state", 32'(u_main.state_q[0]), ST_OFF);
    rst_m = 1'b0;
    wait_change(0, 2'd0, 8, cyc, v);
    check_eq("restart_val", 32'(v), 32'd64);
    check_eq("restart_cyc", 32'(cyc), 32'd4);

    // Saturation: STEP=255, TICK_DIV=2.
    pat_s   = 4'b0001;
    mon_sat = 1'b1;
    rst_s   = 1'b0;
    wait_change(1, 2'd0, 6, cyc, v);
    check_eq("sat_up", 32'(v), 32'd255);
    check_eq("sat_up_cyc", 32'(cyc), 32'd2);
    check_eq("sat_state_on", 32'(u_sat.state_q[0]), ST_ON);
    pat_s = 4'b0000;
    wait_change(1, 2'd0, 6, cyc, v);
    check_eq("sat_down", 32'(v), 32'd0);
    check_eq("sat_state_off", 32'(u_sat.state_q[0]), ST_OFF);
    mon_sat = 1'b0;
    check_eq("sat_no_wrap", 32'(sat_viol), 32'd0);

    // PWM duty: single tick to level 128, then 255. n counts edges since release.
    pat_p = 4'b0001;
    rst_p = 1'b0;
    repeat (1025) @(negedge clk);
    check_eq("pwm_level128", 32'(u_pwm.level_q[0]), 32'd128);
    highs = 0;
    ph0 = 1'b0; ph127 = 1'b0; ph128 = 1'b1;
    for (int n = 1026; n <= 1281; n++) begin
      @(negedge clk);
      if (leds_p[0]) highs++;
      if (((n - 1) % 256) == 0)   ph0   = leds_p[0];
      if (((n - 1) % 256) == 127) ph127 = leds_p[0];
      if (((n - 1) % 256) == 128) ph128 = leds_p[0];
    end
    check_eq("duty_128", 32'(highs), 32'd128);
    check_eq("phase_cnt0", 32'(ph0), 32'd1);
    check_eq("phase_cnt127", 32'(ph127), 32'd1);
    check_eq("phase_cnt128", 32'(ph128), 32'd0);
    repeat (2049 - 1281) @(negedge clk);
    check_eq("pwm_level255", 32'(u_pwm.level_q[0]), 32'd255);
    highs = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (leds_p[0]) highs++;
    end
    check_eq("duty_full", 32'(highs), 32'd256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
